// File: rtl/on_the_fly_noc2node.sv
// on_the_fly_noc2node: NoC->node pending-transaction table with per-entry ageing.
// Ports: clk/rst (async active-low), new_* insert from the depacketizer,
// query_*/delete_transaction_i from the node reply path, combinational hit,
// registered drop/occupancy/full/empty flags, registered timeout report.
`ifndef TABLE_PENDING_NOC2NODE_WIDTH
`define TABLE_PENDING_NOC2NODE_WIDTH 8
`endif
`ifndef N_BIT_SRC_HEAD_FLIT
`define N_BIT_SRC_HEAD_FLIT 4
`endif
`ifndef N_BIT_DEST_HEAD_FLIT
`define N_BIT_DEST_HEAD_FLIT 4
`endif
`ifndef N_BIT_CMD_HEAD_FLIT
`define N_BIT_CMD_HEAD_FLIT 3
`endif

module on_the_fly_noc2node #(
    parameter int DEPTH          = `TABLE_PENDING_NOC2NODE_WIDTH,
    parameter int N_BITS_POINTER = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int N_BITS_AGE     = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             new_pending_transaction_i,
    input  logic [`N_BIT_SRC_HEAD_FLIT-1:0]  new_sender_i,
    input  logic [`N_BIT_DEST_HEAD_FLIT-1:0] new_recipient_i,
    input  logic [`N_BIT_CMD_HEAD_FLIT-1:0]  new_transaction_type_i,
    input  logic                             query_i,
    input  logic [`N_BIT_SRC_HEAD_FLIT-1:0]  query_sender_i,
    input  logic [`N_BIT_DEST_HEAD_FLIT-1:0] query_recipient_i,
    input  logic [`N_BIT_CMD_HEAD_FLIT-1:0]  query_transaction_type_i,
    input  logic                             delete_transaction_i,
    output logic                             is_a_pending_transaction_o,
    output logic                             insert_dropped_o,
    output logic                             table_full_o,
    output logic                             table_empty_o,
    output logic [N_BITS_POINTER:0]          occupancy_o,
    output logic                             timeout_o,
    output logic [`N_BIT_SRC_HEAD_FLIT-1:0]  timeout_sender_o,
    output logic [`N_BIT_DEST_HEAD_FLIT-1:0] timeout_recipient_o,
    output logic [`N_BIT_CMD_HEAD_FLIT-1:0]  timeout_transaction_type_o
);
    localparam int SW = `N_BIT_SRC_HEAD_FLIT;
    localparam int RW = `N_BIT_DEST_HEAD_FLIT;
    localparam int TW = `N_BIT_CMD_HEAD_FLIT;
    localparam int OW = N_BITS_POINTER + 1;
    localparam logic [N_BITS_AGE-1:0] AGE_MAX = N_BITS_AGE'(TIMEOUT_CYCLES - 1);

    logic [DEPTH-1:0]      r_valid;
    logic [SW-1:0]         r_sender    [DEPTH];
    logic [RW-1:0]         r_recipient [DEPTH];
    logic [TW-1:0]         r_type      [DEPTH];
    logic [N_BITS_AGE-1:0] r_age       [DEPTH];
    logic [OW-1:0]         r_occupancy;
    logic                  r_full, r_empty, r_drop, r_timeout;
    logic [SW-1:0]         r_to_sender;
    logic [RW-1:0]         r_to_recipient;
    logic [TW-1:0]         r_to_type;

    logic                      w_hit, w_free_any, w_exp_any, w_ins, w_del;
    logic [N_BITS_POINTER-1:0] w_sel, w_free, w_exp;
    logic [OW-1:0]             w_occ_nxt;

    // Descending scans so the lowest index wins for match, free slot and expiry.
    // A deleted entry never expires in the same cycle.
    always_comb begin
        w_hit      = 1'b0;
        w_sel      = '0;
        w_free_any = 1'b0;
        w_free     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && r_sender[i] == query_sender_i && r_recipient[i] == query_recipient_i
                && r_type[i] == query_transaction_type_i) begin
                w_hit = 1'b1;
                w_sel = N_BITS_POINTER'(i);
            end
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free     = N_BITS_POINTER'(i);
            end
        end
        w_hit     = w_hit && query_i;
        w_del     = w_hit && delete_transaction_i;
        w_ins     = new_pending_transaction_i && !r_full && w_free_any;
        w_exp_any = 1'b0;
        w_exp     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && r_age[i] == AGE_MAX && !(w_del && w_sel == N_BITS_POINTER'(i))) begin
                w_exp_any = 1'b1;
                w_exp     = N_BITS_POINTER'(i);
            end
        end
        w_occ_nxt = r_occupancy + OW'(w_ins) - OW'(w_del) - OW'(w_exp_any);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_sender[i]    <= '0;
                r_recipient[i] <= '0;
                r_type[i]      <= '0;
                r_age[i]       <= '0;
            end
            r_occupancy    <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_drop         <= 1'b0;
            r_timeout      <= 1'b0;
            r_to_sender    <= '0;
            r_to_recipient <= '0;
            r_to_type      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (r_valid[i]) r_age[i] <= r_age[i] + 1'b1;
            if (w_del) r_valid[w_sel] <= 1'b0;
            if (w_exp_any) begin
                r_valid[w_exp] <= 1'b0;
                r_to_sender    <= r_sender[w_exp];
                r_to_recipient <= r_recipient[w_exp];
                r_to_type      <= r_type[w_exp];
            end
            // The free slot is taken from pre-edge state, so it never collides
            // with the entry being deleted or expired at this edge.
            if (w_ins) begin
                r_valid[w_free]     <= 1'b1;
                r_age[w_free]       <= '0;
                r_sender[w_free]    <= new_sender_i;
                r_recipient[w_free] <= new_recipient_i;
                r_type[w_free]      <= new_transaction_type_i;
            end
            r_drop      <= new_pending_transaction_i && r_full;
            r_timeout   <= w_exp_any;
            r_occupancy <= w_occ_nxt;
            r_full      <= w_occ_nxt == OW'(DEPTH);
            r_empty     <= w_occ_nxt == '0;
        end
    end

    assign is_a_pending_transaction_o = w_hit;
    assign insert_dropped_o           = r_drop;
    assign table_full_o               = r_full;
    assign table_empty_o              = r_empty;
    assign occupancy_o                = r_occupancy;
    assign timeout_o                  = r_timeout;
    assign timeout_sender_o           = r_to_sender;
    assign timeout_recipient_o        = r_to_recipient;
    assign timeout_transaction_type_o = r_to_type;
endmodule

// File: doc/on_the_fly_noc2node.md
# on_the_fly_noc2node

Pending-transaction table for the NoC→node direction of the NIC: it records every request head flit (sender, recipient, command) delivered from the NoC to the local node, until the node's reply is matched and retired. It is the responder-side counterpart of the node→NoC pending table. It sits between the NoC-side depacketizer (insert) and the node-side reply path (query/delete). Entries the node never answers are expired by a per-entry age counter and reported for error handling.

## Interface
- `DEPTH`, default `` `TABLE_PENDING_NOC2NODE_WIDTH ``: number of table entries (≥2).
- `N_BITS_POINTER`, default `clog2(DEPTH)`: entry index width.
- `TIMEOUT_CYCLES`, default 1024: cycles an entry may stay valid before expiry (≥2).
- `N_BITS_AGE`, default `clog2(TIMEOUT_CYCLES)`: age counter width.

Ports:
- `clk`: in, 1 bit. Only clock; all state updates on the rising edge.
- `rst`: in, 1 bit. Reset, asynchronous assert, active-low.
- `new_pending_transaction_i`: in, 1 bit. Insert request, sampled at `clk`.
- `new_sender_i`: in, `` `N_BIT_SRC_HEAD_FLIT ``. Source field of the incoming request.
- `new_recipient_i`: in, `` `N_BIT_DEST_HEAD_FLIT ``. Destination field.
- `new_transaction_type_i`: in, `` `N_BIT_CMD_HEAD_FLIT ``. Command field.
- `query_i`: in, 1 bit. Lookup enable.
- `query_sender_i`, `query_recipient_i`, `query_transaction_type_i`: in, same widths as the `new_*` fields. Lookup key.
- `delete_transaction_i`: in, 1 bit. Retire the matched entry at the next edge.
- `is_a_pending_transaction_o`: out, 1 bit. Combinational hit: `query_i` and a valid entry exactly matches the key.
- `insert_dropped_o`: out, 1 bit. Registered one-cycle pulse: the insert was rejected because the table was full.
- `table_full_o`, `table_empty_o`: out, 1 bit each. Registered, reflect current occupancy.
- `occupancy_o`: out, `N_BITS_POINTER+1`. Number of valid entries, registered.
- `timeout_o`: out, 1 bit. Registered one-cycle pulse: an entry expired.
- `timeout_sender_o`, `timeout_recipient_o`, `timeout_transaction_type_o`: out. Fields of the expired entry; valid while `timeout_o` is high and held otherwise.

## Operation
- State per entry:
  - valid bit
  - sender, recipient and type fields
  - age counter (`N_BITS_AGE`)
- Insert: `new_pending_transaction_i` with `table_full_o`=0 writes the lowest-index invalid entry, sets valid and sets age to 0. Duplicate keys are stored as separate entries.
- Rejected insert: `new_pending_transaction_i` with `table_full_o`=1 leaves the table unchanged and raises `insert_dropped_o` for the next cycle.
- Query: match means valid && all three fields equal. With several matches, the lowest-index match is the selected entry.
- Delete: `query_i && delete_transaction_i && hit` clears valid of the selected entry at the edge. A delete with no hit does nothing.
- Ageing: every valid entry increments its age each cycle. An entry whose age equals `TIMEOUT_CYCLES-1` at an edge is invalidated, and `timeout_o` plus its fields are registered.
  - At most one insert is accepted per cycle, so no two entries share an age and at most one entry expires per cycle.
- `occupancy_o` next = occupancy + accepted insert − delete − expiry. `table_full_o` = (occupancy == `DEPTH`); `table_empty_o` = (occupancy == 0).

## Timing
- Reset (`rst`=0, asynchronous):
  - all valid bits, ages and `occupancy_o` = 0
  - `table_empty_o`=1, `table_full_o`=0
  - `insert_dropped_o`=0, `timeout_o`=0, timeout fields = 0
  - `is_a_pending_transaction_o`=0
  - Reset mid-operation discards all entries with no timeout report.
- Latency:
  - An insert at edge N is queryable (hit) in cycle N+1.
  - A delete at edge N makes the entry miss from cycle N+1.
  - Hit has zero latency (combinational).
- Simultaneous insert and delete, table full: the full decision uses pre-edge state, so the insert is dropped even though a slot frees at the same edge.
- Simultaneous insert and delete, table not full: both occur. The inserted entry goes to the lowest pre-edge free slot, never the slot being deleted.
- Delete and expiry of the same entry in the same cycle: the delete wins and `timeout_o` stays 0. A query on an entry in its expiry cycle still reports a hit.
- Query and insert of the same key in the same cycle: the new entry is not visible (miss unless an older copy exists).

## Test plan
- Reset release, insert (1,2,0), idle one cycle, query (1,2,0) with delete → hit=1, occupancy 1→0, `table_empty_o`=1 next cycle.
- Insert (2,2,0) while deleting (1,2,0) in the same cycle, then query (1,2,0) → miss; query (2,2,0) → hit; occupancy=1.
- Fill all `DEPTH` entries, then insert (7,1,3) together with a delete of a hit → `insert_dropped_o`=1, occupancy=`DEPTH`−1; a retry next cycle is accepted and sets full=1.
- Insert (5,4,1) twice, delete once → the second query still hits (occupancy 2→1); a second delete empties the table.
- `TIMEOUT_CYCLES`=8: insert (3,2,0) and never query → `timeout_o` pulses exactly once, 8 cycles after the insert edge, with fields (3,2,0); occupancy returns to 0. Repeat with a delete in the expiry cycle → no pulse.
- Assert `rst`=0 asynchronously with 3 entries valid → outputs take reset values immediately, with no timeout or drop pulses after release.
